// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_pkg                                                   |
// | Description : Shared geometry, FSM encoding and address-field helpers for  |
// |               the direct-mapped write-back L1 data cache.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

`ifndef DCACHE_PKG_MACROS
`define DCACHE_PKG_MACROS
// Address-field extraction: tag | index | byte offset
`define DC_TAG(a)  a[dcache_pkg::ADDR_W-1 : dcache_pkg::OFFSET_W+dcache_pkg::INDEX_W]
`define DC_IDX(a)  a[dcache_pkg::OFFSET_W+dcache_pkg::INDEX_W-1 : dcache_pkg::OFFSET_W]
`define DC_WSEL(a) a[dcache_pkg::OFFSET_W-1 : dcache_pkg::WSEL_LSB]
`endif

package dcache_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 256;
    localparam int NUM_LINES      = 16;

    localparam int OFFSET_W       = 5;
    localparam int INDEX_W        = 4;
    localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;   // 23

    // Word select inside a line: addr[4:2]
    localparam int WSEL_LSB       = 2;
    localparam int WSEL_W         = OFFSET_W - WSEL_LSB;           // 3
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;               // 8

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_if                                                    |
// | Description : CPU-side request bus and memory-side line-transfer bus of    |
// |               the data cache. slave = cache view, master = pipeline/memory.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface dcache_if;
    import dcache_pkg::*;

    logic                cpu_req_i;
    logic                cpu_we_i;
    logic [ADDR_W-1:0]   cpu_addr_i;
    logic [WORD_W-1:0]   cpu_data_i;
    logic [WORD_W-1:0]   cpu_data_o;
    logic                cpu_stall_o;

    logic                mem_req_o;
    logic                mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [LINE_W-1:0]   mem_data_o;
    logic                mem_ack_i;
    logic [LINE_W-1:0]   mem_data_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i
    );

endinterface

`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_sram                                                  |
// | Description : Tag, valid, dirty and line-data storage. Asynchronous read,  |
// |               synchronous write of a full line or of a single word.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [INDEX_W-1:0]  idx_i,
    // read port
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [LINE_W-1:0]   line_o,
    // full-line install (refill): sets valid, clears dirty
    input  logic                line_we_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [LINE_W-1:0]   line_i,
    // single-word store: sets dirty
    input  logic                word_we_i,
    input  logic [WSEL_W-1:0]   word_sel_i,
    input  logic [WORD_W-1:0]   word_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Bit offset of the selected word inside the line
    logic [7:0] word_base;
    assign word_base = {word_sel_i, 5'd0};

    // Status bits are the only state cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            data_q[idx_i] <= line_i;
            tag_q[idx_i]  <= tag_i;
        end else if (word_we_i) begin
            data_q[idx_i][word_base +: WORD_W] <= word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_controller                                            |
// | Description : Direct-mapped, write-back, write-allocate L1 data cache.     |
// |               Hits complete in the request cycle; misses stall the pipe    |
// |               while a write-back and/or refill line transfer runs.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dcache_controller
    import dcache_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.slave  bus
);

    state_t state_q;
    state_t state_d;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  req_wsel;
    logic [7:0]         rd_base;

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line_data;

    logic               hit;
    logic               line_we;
    logic               word_we;

    // Byte-lane bits are always zero for word-aligned accesses
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.cpu_addr_i[WSEL_LSB-1:0];

    assign req_idx  = `DC_IDX(bus.cpu_addr_i);
    assign req_tag  = `DC_TAG(bus.cpu_addr_i);
    assign req_wsel = `DC_WSEL(bus.cpu_addr_i);
    assign rd_base  = {req_wsel, 5'd0};

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (req_idx),
        .valid_o    (line_valid),
        .dirty_o    (line_dirty),
        .tag_o      (line_tag),
        .line_o     (line_data),
        .line_we_i  (line_we),
        .tag_i      (req_tag),
        .line_i     (bus.mem_data_i),
        .word_we_i  (word_we),
        .word_sel_i (req_wsel),
        .word_i     (bus.cpu_data_i)
    );

    assign hit = bus.cpu_req_i & line_valid & (line_tag == req_tag);

    assign bus.cpu_stall_o = (bus.cpu_req_i & ~hit) | (state_q != ST_IDLE);
    assign bus.cpu_data_o  = (hit & ~bus.cpu_we_i) ? line_data[rd_base +: WORD_W] : '0;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, memory-bus drive and array write enables
    always_comb begin
        state_d        = state_q;
        bus.mem_req_o  = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_addr_o = '0;
        bus.mem_data_o = '0;
        line_we        = 1'b0;
        word_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        // Store hits, including the replay after a refill
                        word_we = bus.cpu_we_i & ~rst_i;
                    end else if (line_valid & line_dirty) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_we_o   = 1'b1;
                bus.mem_addr_o = {line_tag, req_idx, {OFFSET_W{1'b0}}};
                bus.mem_data_o = line_data;
                if (bus.mem_ack_i) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (bus.mem_ack_i) begin
                    // A reset coinciding with the ack must not install the line
                    line_we = ~rst_i;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
